param_scan_mux: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer. It generalises the fixed 4-to-1 4-bit select into a configurable-width, configurable-channel-count block with two modes:

- **Manual select:** a channel is chosen on `sel`.
- **Auto-scan:** a round-robin channel sequencer with a programmable dwell.

The output is a registered sample with a valid/ready handshake. It sits between packed multi-channel data sources and a single downstream consumer.

---
 rtl/param_scan_mux_if.sv | 39 +++
 rtl/param_scan_mux.sv | 148 ++++++++++++++
 tb/tb_param_scan_mux.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/param_scan_mux_if.sv
// Bus bundle for param_scan_mux: packed channel data in, registered sample out.
// Optional feature macro: SCAN_MUX_MASK_EN adds the chan_mask input.
// The master modport is the source/consumer side and the slave modport is the mux.
interface param_scan_mux_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 4,
    parameter int unsigned SW = $clog2(N)
);
    logic [N*W-1:0] d;
    logic [SW-1:0]  sel;
    logic           mode;
    logic           en;
    logic [W-1:0]   q;
    logic [SW-1:0]  q_ch;
    logic           q_valid;
    logic           q_ready;
    logic           sel_err;
`ifdef SCAN_MUX_MASK_EN
    logic [N-1:0]   chan_mask;

    modport master (
        output d, sel, mode, en, q_ready, chan_mask,
        input  q, q_ch, q_valid, sel_err
    );
    modport slave (
        input  d, sel, mode, en, q_ready, chan_mask,
        output q, q_ch, q_valid, sel_err
    );
`else
    modport master (
        output d, sel, mode, en, q_ready,
        input  q, q_ch, q_valid, sel_err
    );
    modport slave (
        input  d, sel, mode, en, q_ready,
        output q, q_ch, q_valid, sel_err
    );
`endif
endinterface

// File: rtl/param_scan_mux.sv
// N-channel, W-bit registered mux with manual select and round-robin auto-scan.
// Output is a registered sample with a valid/ready handshake.
// Optional feature macro: SCAN_MUX_MASK_EN (per-channel scan mask via bus.chan_mask).
module param_scan_mux #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 4,
    parameter int unsigned DWELL = 1,
    localparam int unsigned SW   = $clog2(N)
) (
    input logic              clk,
    input logic              rst_n,
    param_scan_mux_if.slave  bus
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {StManual, StScan} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic [SW-1:0]  q_ch_q, q_ch_d;
    logic           q_valid_q, q_valid_d;
    logic           sel_err_q, sel_err_d;
    logic [SW-1:0]  scan_ptr_q, scan_ptr_d;
    logic [DW-1:0]  dwell_cnt_q, dwell_cnt_d;

    logic           load;
    logic           scan_gate;
    logic           sel_oor;
    logic [SW-1:0]  ch;
    logic [W-1:0]   ch_data;
    logic [SW-1:0]  ptr_next;
    logic [SW-1:0]  ptr_start;

`ifdef SCAN_MUX_MASK_EN
    // Lowest set mask bit; 0 when the mask is empty.
    function automatic logic [SW-1:0] first_set(input logic [N-1:0] m);
        logic [SW-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) r = SW'(i);
        end
        return r;
    endfunction

    // Next set mask bit above p with wrap; stays on p if no other bit is set.
    function automatic logic [SW-1:0] next_set(input logic [SW-1:0] p, input logic [N-1:0] m);
        logic [SW-1:0] r;
        int unsigned   idx;
        r = p;
        for (int unsigned i = N - 1; i >= 1; i--) begin
            idx = (32'(p) + i) % N;
            if (m[idx]) r = SW'(idx);
        end
        return r;
    endfunction
`endif

    // Channel choice, data extraction and load qualification.
    always_comb begin
        ch      = (state_q == StScan) ? scan_ptr_q : bus.sel;
        sel_oor = (state_q == StManual) && (32'(bus.sel) >= N);
        // Out-of-range indices match no channel and yield zero data.
        ch_data = '0;
        for (int k = 0; k < N; k++) begin
            if (ch == SW'(k)) ch_data = bus.d[k*W +: W];
        end
`ifdef SCAN_MUX_MASK_EN
        scan_gate = (state_q != StScan) || bus.chan_mask[scan_ptr_q];
        ptr_next  = next_set(scan_ptr_q, bus.chan_mask);
        ptr_start = first_set(bus.chan_mask);
`else
        scan_gate = 1'b1;
        ptr_next  = (scan_ptr_q == SW'(N - 1)) ? '0 : scan_ptr_q + 1'b1;
        ptr_start = '0;
`endif
        load = bus.en && (!q_valid_q || bus.q_ready) && scan_gate;
    end

    // Next-state: output sample, handshake, mode FSM and scan sequencer.
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        q_ch_d      = q_ch_q;
        q_valid_d   = q_valid_q;
        sel_err_d   = 1'b0;
        scan_ptr_d  = scan_ptr_q;
        dwell_cnt_d = dwell_cnt_q;

        if (load) begin
            q_d       = ch_data;
            q_ch_d    = ch;
            q_valid_d = 1'b1;
            sel_err_d = sel_oor;
        end else if (q_valid_q && bus.q_ready) begin
            q_valid_d = 1'b0;
        end

        case (state_q)
            StManual: begin
                if (bus.mode) begin
                    state_d     = StScan;
                    scan_ptr_d  = ptr_start;
                    dwell_cnt_d = '0;
                end
            end
            StScan: begin
                if (!bus.mode) state_d = StManual;
                if (load) begin
                    if (dwell_cnt_q == DW'(DWELL - 1)) begin
                        dwell_cnt_d = '0;
                        scan_ptr_d  = ptr_next;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StManual;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StManual;
            q_q         <= '0;
            q_ch_q      <= '0;
            q_valid_q   <= 1'b0;
            sel_err_q   <= 1'b0;
            scan_ptr_q  <= '0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            q_ch_q      <= q_ch_d;
            q_valid_q   <= q_valid_d;
            sel_err_q   <= sel_err_d;
            scan_ptr_q  <= scan_ptr_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.q_ch    = q_ch_q;
    assign bus.q_valid = q_valid_q;
    assign bus.sel_err = sel_err_q;

endmodule

// File: tb/tb_param_scan_mux.sv
// Directed bench for param_scan_mux: three instances cover N=4/DWELL=1,
// N=4/DWELL=2 and N=3 (out-of-range select). Mask test only with SCAN_MUX_MASK_EN.
module tb_param_scan_mux;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    param_scan_mux_if #(.N(4), .W(4)) if_a ();
    param_scan_mux_if #(.N(4), .W(4)) if_b ();
    param_scan_mux_if #(.N(3), .W(4)) if_c ();

    param_scan_mux #(.N(4), .W(4), .DWELL(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    param_scan_mux #(.N(4), .W(4), .DWELL(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    param_scan_mux #(.N(3), .W(4), .DWELL(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_init();
        total++;
        if ({if_a.q, if_a.q_ch, if_a.q_valid, if_a.sel_err} !== 8'h00) begin
            $display("FAIL reset_init q=%h q_ch=%0d q_valid=%b sel_err=%b want all 0",
                     if_a.q, if_a.q_ch, if_a.q_valid, if_a.sel_err);
            bad++;
        end
    endtask

    task automatic test_manual();
        logic [3:0] exp_q [4];
        exp_q[0] = 4'h3; exp_q[1] = 4'hA; exp_q[2] = 4'h8; exp_q[3] = 4'hD;
        if_a.d = 16'hD8A3; if_a.mode = 1'b0; if_a.en = 1'b1; if_a.q_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            if_a.sel = 2'(s);
            tick();
            total++;
            if (if_a.q !== exp_q[s] || if_a.q_ch !== 2'(s) || if_a.q_valid !== 1'b1
                || if_a.sel_err !== 1'b0) begin
                $display("FAIL manual sel=%0d q=%h q_ch=%0d v=%b err=%b want q=%h q_ch=%0d v=1 err=0",
                         s, if_a.q, if_a.q_ch, if_a.q_valid, if_a.sel_err, exp_q[s], s);
                bad++;
            end
        end
    endtask

    task automatic test_reset_midrun();
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({if_a.q, if_a.q_ch, if_a.q_valid, if_a.sel_err} !== 8'h00) begin
            $display("FAIL reset_midrun q=%h q_ch=%0d q_valid=%b sel_err=%b want all 0",
                     if_a.q, if_a.q_ch, if_a.q_valid, if_a.sel_err);
            bad++;
        end
        if_a.en = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        total++;
        if (if_a.q_valid !== 1'b0) begin
            $display("FAIL reset_hold q_valid=%b want 0", if_a.q_valid);
            bad++;
        end
    endtask

    task automatic test_scan_wrap();
        logic [3:0] exp_q  [9];
        logic [1:0] exp_ch [9];
        for (int i = 0; i < 9; i++) begin
            exp_ch[i] = 2'((i / 2) % 4);
            exp_q[i]  = 4'(((i / 2) % 4) + 1);
        end
        if_b.d = 16'h4321; if_b.q_ready = 1'b1; if_b.mode = 1'b1; if_b.en = 1'b0;
        tick();
        if_b.en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            total++;
            if (if_b.q !== exp_q[i] || if_b.q_ch !== exp_ch[i] || if_b.q_valid !== 1'b1) begin
                $display("FAIL scan_wrap step=%0d q=%h q_ch=%0d v=%b want q=%h q_ch=%0d v=1",
                         i, if_b.q, if_b.q_ch, if_b.q_valid, exp_q[i], exp_ch[i]);
                bad++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_q  [4];
        logic [1:0] exp_ch [4];
        exp_q[0] = 4'h1; exp_ch[0] = 2'd0;
        exp_q[1] = 4'h2; exp_ch[1] = 2'd1;
        exp_q[2] = 4'h2; exp_ch[2] = 2'd1;
        exp_q[3] = 4'h3; exp_ch[3] = 2'd2;
        if_b.q_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (if_b.q !== 4'h1 || if_b.q_ch !== 2'd0 || if_b.q_valid !== 1'b1
                || u_b.scan_ptr_q !== 2'd0) begin
                $display("FAIL stall cyc=%0d q=%h q_ch=%0d v=%b ptr=%0d want q=1 q_ch=0 v=1 ptr=0",
                         i, if_b.q, if_b.q_ch, if_b.q_valid, u_b.scan_ptr_q);
                bad++;
            end
        end
        if_b.q_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (if_b.q !== exp_q[i] || if_b.q_ch !== exp_ch[i] || if_b.q_valid !== 1'b1) begin
                $display("FAIL resume step=%0d q=%h q_ch=%0d v=%b want q=%h q_ch=%0d v=1",
                         i, if_b.q, if_b.q_ch, if_b.q_valid, exp_q[i], exp_ch[i]);
                bad++;
            end
        end
        if_b.en = 1'b0;
        tick();
        total++;
        if (if_b.q_valid !== 1'b0 || if_b.q !== 4'h3 || if_b.q_ch !== 2'd2) begin
            $display("FAIL drain q=%h q_ch=%0d v=%b want q=3 q_ch=2 v=0",
                     if_b.q, if_b.q_ch, if_b.q_valid);
            bad++;
        end
    endtask

    task automatic test_out_of_range();
        if_c.d = 12'h987; if_c.mode = 1'b0; if_c.en = 1'b1; if_c.q_ready = 1'b1;
        if_c.sel = 2'd3;
        tick();
        total++;
        if (if_c.q !== 4'h0 || if_c.q_ch !== 2'd3 || if_c.sel_err !== 1'b1
            || if_c.q_valid !== 1'b1) begin
            $display("FAIL oor_load q=%h q_ch=%0d err=%b v=%b want q=0 q_ch=3 err=1 v=1",
                     if_c.q, if_c.q_ch, if_c.sel_err, if_c.q_valid);
            bad++;
        end
        if_c.sel = 2'd2;
        tick();
        total++;
        if (if_c.q !== 4'h9 || if_c.q_ch !== 2'd2 || if_c.sel_err !== 1'b0) begin
            $display("FAIL oor_clear q=%h q_ch=%0d err=%b want q=9 q_ch=2 err=0",
                     if_c.q, if_c.q_ch, if_c.sel_err);
            bad++;
        end
        if_c.sel = 2'd3; if_c.en = 1'b0;
        tick();
        total++;
        if (if_c.sel_err !== 1'b0 || if_c.q_valid !== 1'b0) begin
            $display("FAIL oor_noload err=%b v=%b want err=0 v=0", if_c.sel_err, if_c.q_valid);
            bad++;
        end
    endtask

`ifdef SCAN_MUX_MASK_EN
    task automatic test_mask();
        logic [3:0] exp_q  [4];
        logic [1:0] exp_ch [4];
        exp_q[0] = 4'hA; exp_ch[0] = 2'd1;
        exp_q[1] = 4'hD; exp_ch[1] = 2'd3;
        exp_q[2] = 4'hA; exp_ch[2] = 2'd1;
        exp_q[3] = 4'hD; exp_ch[3] = 2'd3;
        if_a.d = 16'hD8A3; if_a.chan_mask = 4'b1010; if_a.mode = 1'b1; if_a.en = 1'b0;
        if_a.q_ready = 1'b1;
        tick();
        if_a.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (if_a.q !== exp_q[i] || if_a.q_ch !== exp_ch[i] || if_a.q_valid !== 1'b1) begin
                $display("FAIL mask step=%0d q=%h q_ch=%0d v=%b want q=%h q_ch=%0d v=1",
                         i, if_a.q, if_a.q_ch, if_a.q_valid, exp_q[i], exp_ch[i]);
                bad++;
            end
        end
        if_a.chan_mask = 4'b0000;
        tick();
        total++;
        if (if_a.q_valid !== 1'b0 || if_a.q_ch !== 2'd3) begin
            $display("FAIL mask_empty v=%b q_ch=%0d want v=0 q_ch=3", if_a.q_valid, if_a.q_ch);
            bad++;
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        if_a.d = '0; if_a.sel = '0; if_a.mode = 1'b0; if_a.en = 1'b0; if_a.q_ready = 1'b0;
        if_b.d = '0; if_b.sel = '0; if_b.mode = 1'b0; if_b.en = 1'b0; if_b.q_ready = 1'b0;
        if_c.d = '0; if_c.sel = '0; if_c.mode = 1'b0; if_c.en = 1'b0; if_c.q_ready = 1'b0;
`ifdef SCAN_MUX_MASK_EN
        if_a.chan_mask = '1; if_b.chan_mask = '1; if_c.chan_mask = '1;
`endif
        #12;
        test_reset_init();
        rst_n = 1'b1;
        tick();
        test_manual();
        test_reset_midrun();
        test_scan_wrap();
        test_backpressure();
        test_out_of_range();
`ifdef SCAN_MUX_MASK_EN
        test_mask();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
